// File: rtl/tawas_dbus_arb.sv
// Data-bus arbiter: the core load/store unit has absolute priority; a secondary
// requester (DMA/debug) gets leftover cycles plus a starvation-driven core hold.
module tawas_dbus_arb #(
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        C_CS,
  input  logic        C_WR,
  input  logic [31:0] C_ADDR,
  input  logic [3:0]  C_MASK,
  input  logic [31:0] C_DOUT,
  output logic [31:0] C_DIN,
  input  logic        S_REQ,
  input  logic        S_WR,
  input  logic [31:0] S_ADDR,
  input  logic [3:0]  S_MASK,
  input  logic [31:0] S_WDATA,
  output logic        S_ACK,
  output logic        S_RVLD,
  output logic [31:0] S_RDATA,
  input  logic        S_RRDY,
  output logic [31:0] DADDR,
  output logic        DCS,
  output logic        DWR,
  output logic [3:0]  DMASK,
  output logic [31:0] DOUT,
  input  logic [31:0] DIN,
  output logic        CORE_HOLD,
  output logic        HOLD_ERR
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} sec_state_e;

  sec_state_e  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        core_hold_q, core_hold_d;
  logic        hold_err_q, hold_err_d;
  logic        rfirst_q, rfirst_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] daddr_q, daddr_d;
  logic        dcs_q, dcs_d;
  logic        dwr_q, dwr_d;
  logic [3:0]  dmask_q, dmask_d;
  logic [31:0] dout_q, dout_d;
  logic        s_ack;

  always_comb begin
    s_ack       = RST_N && (state_q == ST_IDLE) && S_REQ && !C_CS;
    state_d     = state_q;
    rfirst_d    = 1'b0;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;
    core_hold_d = 1'b0;
    hold_err_d  = hold_err_q | (core_hold_q & C_CS);
    daddr_d     = '0;
    dcs_d       = 1'b0;
    dwr_d       = 1'b0;
    dmask_d     = '0;
    dout_d      = '0;

    case (state_q)
      ST_IDLE: if (s_ack && !S_WR) state_d = ST_WAIT;
      ST_WAIT: begin
        state_d  = ST_RESP;
        rfirst_d = 1'b1;
      end
      ST_RESP: begin
        // Memory data is only valid in the first RESP cycle; latch it for the hold-off.
        if (rfirst_q) rdata_d = DIN;
        if (S_RRDY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!S_REQ || s_ack) begin
      cnt_d = '0;
    end else if ((state_q == ST_IDLE) && C_CS) begin
      if (cnt_q >= LIMIT - 8'd1) begin
        cnt_d       = '0;
        core_hold_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    if (C_CS) begin
      daddr_d = C_ADDR;
      dcs_d   = 1'b1;
      dwr_d   = C_WR;
      dmask_d = C_MASK;
      dout_d  = C_WR ? C_DOUT : '0;
    end else if (s_ack) begin
      daddr_d = S_ADDR;
      dcs_d   = 1'b1;
      dwr_d   = S_WR;
      dmask_d = S_MASK;
      dout_d  = S_WR ? S_WDATA : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      core_hold_q <= 1'b0;
      hold_err_q  <= 1'b0;
      rfirst_q    <= 1'b0;
      rdata_q     <= '0;
      daddr_q     <= '0;
      dcs_q       <= 1'b0;
      dwr_q       <= 1'b0;
      dmask_q     <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      core_hold_q <= core_hold_d;
      hold_err_q  <= hold_err_d;
      rfirst_q    <= rfirst_d;
      rdata_q     <= rdata_d;
      daddr_q     <= daddr_d;
      dcs_q       <= dcs_d;
      dwr_q       <= dwr_d;
      dmask_q     <= dmask_d;
      dout_q      <= dout_d;
    end
  end

  assign C_DIN     = DIN;
  assign S_ACK     = s_ack;
  assign S_RVLD    = (state_q == ST_RESP);
  assign S_RDATA   = rfirst_q ? DIN : rdata_q;
  assign DADDR     = daddr_q;
  assign DCS       = dcs_q;
  assign DWR       = dwr_q;
  assign DMASK     = dmask_q;
  assign DOUT      = dout_q;
  assign CORE_HOLD = core_hold_q;
  assign HOLD_ERR  = hold_err_q;

endmodule

// File: tb/tb_tawas_dbus_arb.sv
// Scoreboard bench for tawas_dbus_arb: memory-port transactions and secondary
// read responses are queued at stimulus time and checked when they appear.
module tb_tawas_dbus_arb;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        C_CS, C_WR;
  logic [31:0] C_ADDR, C_DOUT, C_DIN;
  logic [3:0]  C_MASK;
  logic        S_REQ, S_WR, S_ACK, S_RVLD, S_RRDY;
  logic [31:0] S_ADDR, S_WDATA, S_RDATA;
  logic [3:0]  S_MASK;
  logic [31:0] DADDR, DOUT;
  logic [31:0] DIN = '0;
  logic        DCS, DWR, CORE_HOLD, HOLD_ERR;
  logic [3:0]  DMASK;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] dout;
  } txn_t;

  txn_t        mq[$];
  logic [31:0] rq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        mon_en   = 1'b0;

  always #5 CLK = ~CLK;

  tawas_dbus_arb #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .C_CS(C_CS), .C_WR(C_WR), .C_ADDR(C_ADDR), .C_MASK(C_MASK), .C_DOUT(C_DOUT), .C_DIN(C_DIN),
    .S_REQ(S_REQ), .S_WR(S_WR), .S_ADDR(S_ADDR), .S_MASK(S_MASK), .S_WDATA(S_WDATA),
    .S_ACK(S_ACK), .S_RVLD(S_RVLD), .S_RDATA(S_RDATA), .S_RRDY(S_RRDY),
    .DADDR(DADDR), .DCS(DCS), .DWR(DWR), .DMASK(DMASK), .DOUT(DOUT), .DIN(DIN),
    .CORE_HOLD(CORE_HOLD), .HOLD_ERR(HOLD_ERR)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hA5A5_A5A5 : ((a * 32'h9E37_79B1) ^ 32'h0F0F_0F0F);
  endfunction

  // Synchronous memory: data for a cycle with DCS high appears the next cycle.
  always @(posedge CLK) DIN <= DCS ? mem_fn(DADDR) : 32'h0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_mem(input logic [31:0] a, input logic w, input logic [3:0] m, input logic [31:0] d);
    txn_t t;
    t.addr = a; t.wr = w; t.mask = m; t.dout = w ? d : 32'h0;
    mq.push_back(t);
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic mid();
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    C_CS = 0; C_WR = 0; C_ADDR = '0; C_MASK = '0; C_DOUT = '0;
    S_REQ = 0; S_WR = 0; S_ADDR = '0; S_MASK = '0; S_WDATA = '0; S_RRDY = 0;
  endtask

  always @(negedge CLK) begin
    txn_t t;
    if (mon_en) begin
      if (DCS) begin
        if (mq.size() == 0) check_val("unexpected_dcs", 32'd1, 32'd0);
        else begin
          t = mq.pop_front();
          check_val("daddr", DADDR, t.addr);
          check_val("dwr", {31'h0, DWR}, {31'h0, t.wr});
          check_val("dmask", {28'h0, DMASK}, {28'h0, t.mask});
          check_val("dout", DOUT, t.dout);
        end
      end else begin
        check_val("port_idle", DADDR | DOUT | {28'h0, DMASK} | {31'h0, DWR}, 32'h0);
      end
      if (S_RVLD) begin
        if (rq.size() == 0) check_val("unexpected_rvld", 32'd1, 32'd0);
        else begin
          check_val("s_rdata", S_RDATA, rq[0]);
          if (S_RRDY) void'(rq.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with both requesters active
    RST_N = 0; idle_inputs();
    C_CS = 1; C_ADDR = 32'h55; S_REQ = 1; S_ADDR = 32'h66;
    mid(); check_val("rst_sack_pre", {31'h0, S_ACK}, 32'd0);
    next_cycle(); mon_en = 1;
    mid();
    check_val("rst_sack", {31'h0, S_ACK}, 32'd0);
    check_val("rst_rvld", {31'h0, S_RVLD}, 32'd0);
    check_val("rst_hold", {31'h0, CORE_HOLD}, 32'd0);
    check_val("rst_holderr", {31'h0, HOLD_ERR}, 32'd0);
    check_val("rst_rdata", S_RDATA, 32'h0);
    check_val("rst_dcs", {31'h0, DCS}, 32'd0);
    next_cycle(); RST_N = 1; idle_inputs();

    // Core read then core write, granted from the first released cycle
    C_CS = 1; C_ADDR = 32'h100; C_MASK = 4'hF; C_DOUT = 32'hFFFF_FFFF;
    push_mem(32'h100, 0, 4'hF, 32'h0);
    mid(); check_val("core_no_sack", {31'h0, S_ACK}, 32'd0);
    next_cycle(); C_WR = 1; C_ADDR = 32'h104; C_MASK = 4'h5; C_DOUT = 32'hCAFE_F00D;
    push_mem(32'h104, 1, 4'h5, 32'hCAFE_F00D);
    mid(); check_val("core_dcs_t1", {31'h0, DCS}, 32'd1); check_val("core_daddr_t1", DADDR, 32'h100);
    next_cycle(); C_CS = 0; C_WR = 0;
    mid(); check_val("core_rdata_t2", C_DIN, 32'hA5A5_A5A5);

    // Secondary read with delayed S_RRDY, a queued request and a core read in WAIT
    next_cycle();
    S_REQ = 1; S_WR = 0; S_ADDR = 32'h200; S_MASK = 4'hF; S_WDATA = 32'h1111;
    push_mem(32'h200, 0, 4'hF, 32'h0); rq.push_back(mem_fn(32'h200));
    mid(); check_val("srd_ack_t", {31'h0, S_ACK}, 32'd1);
    next_cycle(); S_ADDR = 32'h208;
    C_CS = 1; C_ADDR = 32'h10C; C_MASK = 4'hF; push_mem(32'h10C, 0, 4'hF, 32'h0);
    mid(); check_val("srd_wait_ack", {31'h0, S_ACK}, 32'd0); check_val("srd_wait_rvld", {31'h0, S_RVLD}, 32'd0);
    next_cycle(); C_CS = 0;
    mid(); check_val("srd_rvld_t2", {31'h0, S_RVLD}, 32'd1); check_val("srd_resp_ack", {31'h0, S_ACK}, 32'd0);
    next_cycle();
    mid(); check_val("core_rd_in_wait", C_DIN, mem_fn(32'h10C)); check_val("srd_hold_ack", {31'h0, S_ACK}, 32'd0);
    next_cycle();
    mid(); check_val("srd_hold_rvld", {31'h0, S_RVLD}, 32'd1); check_val("srd_hold_ack2", {31'h0, S_ACK}, 32'd0);
    next_cycle(); S_RRDY = 1;
    mid(); check_val("srd_rrdy_ack", {31'h0, S_ACK}, 32'd0);
    next_cycle();
    push_mem(32'h208, 0, 4'hF, 32'h0); rq.push_back(mem_fn(32'h208));
    mid(); check_val("srd_next_ack", {31'h0, S_ACK}, 32'd1); check_val("srd_next_rvld", {31'h0, S_RVLD}, 32'd0);
    next_cycle(); S_REQ = 0;
    mid(); next_cycle();
    mid(); check_val("srd2_rvld", {31'h0, S_RVLD}, 32'd1);
    next_cycle();
    mid(); check_val("srd2_done", {31'h0, S_RVLD}, 32'd0);

    // Core priority, then back-to-back secondary writes
    next_cycle(); S_RRDY = 0;
    C_CS = 1; C_ADDR = 32'h110; C_MASK = 4'hF;
    S_REQ = 1; S_WR = 1; S_ADDR = 32'h400; S_MASK = 4'hC; S_WDATA = 32'hBEEF_0001;
    push_mem(32'h110, 0, 4'hF, 32'h0);
    mid(); check_val("prio_no_ack", {31'h0, S_ACK}, 32'd0);
    next_cycle(); C_CS = 0; push_mem(32'h400, 1, 4'hC, 32'hBEEF_0001);
    mid(); check_val("prio_ack_after", {31'h0, S_ACK}, 32'd1);
    next_cycle(); S_ADDR = 32'h300; S_MASK = 4'h3; S_WDATA = 32'h1234; push_mem(32'h300, 1, 4'h3, 32'h1234);
    mid(); check_val("swr_b2b_ack", {31'h0, S_ACK}, 32'd1);
    next_cycle(); S_REQ = 0;
    mid();
    check_val("swr_dwr", {31'h0, DWR}, 32'd1); check_val("swr_dmask", {28'h0, DMASK}, 32'h3);
    check_val("swr_dout", DOUT, 32'h1234); check_val("swr_no_rvld", {31'h0, S_RVLD}, 32'd0);
    next_cycle();
    mid(); check_val("swr_no_rvld2", {31'h0, S_RVLD}, 32'd0);

    // Starvation: core yields in the hold cycle
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      C_CS = 1; C_ADDR = 32'h500 + 32'(4 * i); S_REQ = 1; S_WR = 0; S_ADDR = 32'h600; S_MASK = 4'hF;
      push_mem(C_ADDR, 0, 4'hF, 32'h0);
      mid(); check_val("starve_a_nohold", {31'h0, CORE_HOLD}, 32'd0); check_val("starve_a_noack", {31'h0, S_ACK}, 32'd0);
    end
    next_cycle(); C_CS = 0; push_mem(32'h600, 0, 4'hF, 32'h0); rq.push_back(mem_fn(32'h600));
    mid(); check_val("starve_a_hold", {31'h0, CORE_HOLD}, 32'd1); check_val("starve_a_ack", {31'h0, S_ACK}, 32'd1);
    next_cycle(); S_REQ = 0; S_RRDY = 1;
    mid(); check_val("starve_a_pulse", {31'h0, CORE_HOLD}, 32'd0); check_val("starve_a_noerr", {31'h0, HOLD_ERR}, 32'd0);
    next_cycle(); mid(); next_cycle(); mid();

    // Starvation: core ignores the hold
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      C_CS = 1; C_ADDR = 32'h520 + 32'(4 * i); S_REQ = 1; S_WR = 0; S_ADDR = 32'h640;
      push_mem(C_ADDR, 0, 4'hF, 32'h0);
      mid(); check_val("starve_b_nohold", {31'h0, CORE_HOLD}, 32'd0);
    end
    next_cycle(); C_ADDR = 32'h540; push_mem(32'h540, 0, 4'hF, 32'h0);
    mid();
    check_val("starve_b_hold", {31'h0, CORE_HOLD}, 32'd1); check_val("starve_b_noack", {31'h0, S_ACK}, 32'd0);
    check_val("starve_b_err_pre", {31'h0, HOLD_ERR}, 32'd0);
    next_cycle(); C_CS = 0; S_REQ = 0;
    mid(); check_val("starve_b_err", {31'h0, HOLD_ERR}, 32'd1); check_val("starve_b_pulse", {31'h0, CORE_HOLD}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); mid(); check_val("holderr_sticky", {31'h0, HOLD_ERR}, 32'd1);
    end

    // Reset while a response is pending, then grant in the first released cycle
    next_cycle(); S_RRDY = 0; S_REQ = 1; S_WR = 0; S_ADDR = 32'h700;
    push_mem(32'h700, 0, 4'hF, 32'h0); rq.push_back(mem_fn(32'h700));
    mid(); check_val("rstresp_ack", {31'h0, S_ACK}, 32'd1);
    next_cycle(); S_REQ = 0;
    mid();
    next_cycle(); RST_N = 0; C_CS = 1; C_ADDR = 32'h900;
    mid(); check_val("rstresp_rvld_pre", {31'h0, S_RVLD}, 32'd1);
    next_cycle(); rq.delete(); RST_N = 1; C_CS = 0;
    S_REQ = 1; S_WR = 1; S_ADDR = 32'h800; S_MASK = 4'hF; S_WDATA = 32'h5A;
    push_mem(32'h800, 1, 4'hF, 32'h5A);
    mid();
    check_val("rstresp_rvld", {31'h0, S_RVLD}, 32'd0); check_val("rstresp_dcs", {31'h0, DCS}, 32'd0);
    check_val("rstresp_holderr", {31'h0, HOLD_ERR}, 32'd0); check_val("rstresp_first_ack", {31'h0, S_ACK}, 32'd1);
    next_cycle(); S_REQ = 0; S_RRDY = 1;
    mid(); check_val("rstresp_no_rvld", {31'h0, S_RVLD}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); mid(); check_val("rstresp_no_rvld", {31'h0, S_RVLD}, 32'd0);
    end

    check_val("mem_queue_empty", 32'(mq.size()), 32'd0);
    check_val("resp_queue_empty", 32'(rq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
